// File: rtl/iq_pwr_acc.sv
// I/Q power accumulator: per-sample I^2+Q^2 summed over a 2^WIN_LOG2 window,
// emitting the window average with a threshold flag; a frame-end strobe flushes a partial window.
module iq_pwr_acc #(
  parameter int unsigned DW       = 9,
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned PW       = 2 * DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_data_i,
  input  logic signed [DW-1:0] in_data_q,
  input  logic                 in_en,
  input  logic                 in_done,
  input  logic        [PW-1:0] thr,
  output logic        [PW-1:0] out_pwr,
  output logic                 out_en,
  output logic                 out_det,
  output logic                 out_done
);

  localparam int unsigned AW = PW + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Stage 1: instantaneous power
  logic signed [PW-1:0] ext_i, ext_q, sq_i, sq_q;
  logic        [PW-1:0] p_d, p_q;
  logic                 p_vld_q, d_vld_q;

  // Stage 2: accumulation and output
  state_e               state_d, state_q;
  logic        [AW-1:0] acc_d, acc_q, sum, p_ext;
  logic  [WIN_LOG2-1:0] cnt_d, cnt_q;
  logic        [PW-1:0] avg;
  logic                 win_done, flush, emit;
  logic        [PW-1:0] out_pwr_d;
  logic                 out_det_d;

  always_comb begin
    ext_i = PW'(in_data_i);
    ext_q = PW'(in_data_q);
    sq_i  = ext_i * ext_i;
    sq_q  = ext_q * ext_q;
    // Both squares are non-negative; the sum can exceed the signed range, so add unsigned.
    p_d   = $unsigned(sq_i) + $unsigned(sq_q);
  end

  always_comb begin
    p_ext    = {{WIN_LOG2{1'b0}}, p_q};
    sum      = acc_q + (p_vld_q ? p_ext : '0);
    avg      = sum[AW-1:WIN_LOG2];
    win_done = p_vld_q && (cnt_q == CntMax);
    flush    = d_vld_q;
    // A flush only emits when something has been accumulated (or arrives with it).
    emit     = win_done || (flush && ((state_q == StRun) || p_vld_q));

    out_pwr_d = out_pwr;
    out_det_d = out_det;
    if (emit) begin
      out_pwr_d = avg;
      out_det_d = (avg >= thr);
    end

    if (win_done || flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      acc_d = sum;
      cnt_d = cnt_q + WIN_LOG2'(p_vld_q);
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: if (p_vld_q && !(win_done || flush)) state_d = StRun;
      StRun:  if (win_done || flush)               state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      p_vld_q  <= 1'b0;
      d_vld_q  <= 1'b0;
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_pwr  <= '0;
      out_en   <= 1'b0;
      out_det  <= 1'b0;
      out_done <= 1'b0;
    end else begin
      if (in_en) p_q <= p_d;
      p_vld_q  <= in_en;
      d_vld_q  <= in_done;
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_pwr  <= out_pwr_d;
      out_en   <= emit;
      out_det  <= out_det_d;
      out_done <= flush;
    end
  end

endmodule
